// File: rtl/spi_mem_arbiter_pkg.sv
// rtl/spi_mem_arbiter_pkg.sv - shared types for the SPI memory arbiter and controller
package spi_mem_arbiter_pkg;

  // Access type presented to the SPI flash/PSRAM controller
  typedef enum logic [1:0] {
    TYPE_IMEM_READ  = 2'd0,
    TYPE_DMEM_READ  = 2'd1,
    TYPE_DMEM_WRITE = 2'd2
  } mem_type_t;

  // Arbiter sequencing states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

  // Which requester owns the current transaction
  typedef enum logic {
    GRANT_IMEM = 1'b0,
    GRANT_DMEM = 1'b1
  } grant_t;

  // Controller access type for a data-port request
  function automatic mem_type_t dmem_type(input logic we);
    return we ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - round-robin IMEM/DMEM arbiter in front of the SPI controller; optional fetch buffer under SPI_ARB_FETCH_BUF_EN
module spi_mem_arbiter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              imem_req_in,
  input  logic [ADDR_W-1:0] imem_addr_in,
  output logic [15:0]       imem_data_out,
  output logic              imem_ack_out,
  input  logic              dmem_req_in,
  input  logic              dmem_we_in,
  input  logic [ADDR_W-1:0] dmem_addr_in,
  input  logic [7:0]        dmem_wdata_in,
  output logic [7:0]        dmem_rdata_out,
  output logic              dmem_ack_out,
  output logic [ADDR_W-1:0] ctrl_addr_out,
  output logic              ctrl_addr_valid_out,
  output mem_type_t         ctrl_mem_type_out,
  output logic [7:0]        ctrl_wdata_out,
  input  logic [15:0]       ctrl_flash_data_in,
  input  logic              ctrl_flash_valid_in,
  input  logic [7:0]        ctrl_psram_data_in,
  input  logic              ctrl_psram_valid_in,
  input  logic              ctrl_busy_in
);

  arb_state_t  state;
  grant_t      grant;
  grant_t      last_grant;
  grant_t      pick;
  logic        pick_valid;
  logic [15:0] result;
  logic [15:0] result_next;
  logic        buf_hit;
  logic        fetch_done;

  // Choose the requester to serve next; on a tie the port not served last wins
  always_comb begin
    pick_valid = imem_req_in | dmem_req_in;
    pick       = GRANT_DMEM;
    if (imem_req_in && dmem_req_in) begin
      pick = (last_grant == GRANT_DMEM) ? GRANT_IMEM : GRANT_DMEM;
    end else if (imem_req_in) begin
      pick = GRANT_IMEM;
    end
  end

  // Merge this cycle's controller data into the result register value
  always_comb begin
    result_next = result;
    if (ctrl_flash_valid_in) begin
      result_next = ctrl_flash_data_in;
    end
    if (ctrl_psram_valid_in) begin
      result_next[7:0] = ctrl_psram_data_in;
    end
  end

  assign fetch_done = (state == WAIT_DONE) && !ctrl_busy_in && (grant == GRANT_IMEM);

`ifdef SPI_ARB_FETCH_BUF_EN
  logic [ADDR_W-1:0] tag;
  logic              tag_valid;

  // imem_data_out always holds the word of the last completed flash fetch,
  // so it doubles as the buffer's data and only the address tag is kept here.
  assign buf_hit = tag_valid && (pick == GRANT_IMEM) && (imem_addr_in == tag);

  // Remember the address of the most recent completed flash fetch
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      tag       <= '0;
      tag_valid <= 1'b0;
    end else if (fetch_done) begin
      tag       <= ctrl_addr_out;
      tag_valid <= 1'b1;
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  // Transaction sequencer with registered controller and port outputs
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state               <= IDLE;
      grant               <= GRANT_IMEM;
      last_grant          <= GRANT_DMEM;
      result              <= '0;
      imem_data_out       <= '0;
      imem_ack_out        <= 1'b0;
      dmem_rdata_out      <= '0;
      dmem_ack_out        <= 1'b0;
      ctrl_addr_out       <= '0;
      ctrl_addr_valid_out <= 1'b0;
      ctrl_mem_type_out   <= TYPE_IMEM_READ;
      ctrl_wdata_out      <= '0;
    end else begin
      ctrl_addr_valid_out <= 1'b0;
      imem_ack_out        <= 1'b0;
      dmem_ack_out        <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant      <= pick;
            last_grant <= pick;
            if (buf_hit) begin
              // Repeat fetch of the buffered address: answer without SPI traffic
              imem_ack_out <= 1'b1;
              state        <= RESP;
            end else begin
              ctrl_addr_out       <= (pick == GRANT_IMEM) ? imem_addr_in : dmem_addr_in;
              ctrl_mem_type_out   <= (pick == GRANT_IMEM) ? TYPE_IMEM_READ : dmem_type(dmem_we_in);
              ctrl_wdata_out      <= dmem_wdata_in;
              ctrl_addr_valid_out <= 1'b1;
              state               <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          result <= result_next;
          if (ctrl_busy_in) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          result <= result_next;
          if (!ctrl_busy_in) begin
            state <= RESP;
            if (grant == GRANT_IMEM) begin
              imem_ack_out  <= 1'b1;
              imem_data_out <= result_next;
            end else begin
              dmem_ack_out <= 1'b1;
              if (ctrl_mem_type_out == TYPE_DMEM_READ) begin
                dmem_rdata_out <= result_next[7:0];
              end
            end
          end
        end
        RESP: begin
          // Requests are deliberately not sampled here
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb/tb_spi_mem_arbiter.sv - directed bench for spi_mem_arbiter with a behavioural SPI controller
module tb_spi_mem_arbiter;
  import spi_mem_arbiter_pkg::*;

  localparam int ADDR_W = 16;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic              imem_req_in;
  logic [ADDR_W-1:0] imem_addr_in;
  logic [15:0]       imem_data_out;
  logic              imem_ack_out;
  logic              dmem_req_in;
  logic              dmem_we_in;
  logic [ADDR_W-1:0] dmem_addr_in;
  logic [7:0]        dmem_wdata_in;
  logic [7:0]        dmem_rdata_out;
  logic              dmem_ack_out;
  logic [ADDR_W-1:0] ctrl_addr_out;
  logic              ctrl_addr_valid_out;
  mem_type_t         ctrl_mem_type_out;
  logic [7:0]        ctrl_wdata_out;
  logic [15:0]       ctrl_flash_data_in;
  logic              ctrl_flash_valid_in;
  logic [7:0]        ctrl_psram_data_in;
  logic              ctrl_psram_valid_in;
  logic              ctrl_busy_in;

  int checks = 0;
  int errors = 0;

  int          pulse_cnt = 0;
  logic        mdl_active;
  int          mdl_cnt;
  mem_type_t   mdl_type;
  logic [15:0] mdl_addr;
  logic [7:0]  mdl_wdata;
  logic [7:0]  psram [0:255];

  always #5 clk_in = ~clk_in;

  spi_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .imem_req_in(imem_req_in), .imem_addr_in(imem_addr_in),
    .imem_data_out(imem_data_out), .imem_ack_out(imem_ack_out),
    .dmem_req_in(dmem_req_in), .dmem_we_in(dmem_we_in),
    .dmem_addr_in(dmem_addr_in), .dmem_wdata_in(dmem_wdata_in),
    .dmem_rdata_out(dmem_rdata_out), .dmem_ack_out(dmem_ack_out),
    .ctrl_addr_out(ctrl_addr_out), .ctrl_addr_valid_out(ctrl_addr_valid_out),
    .ctrl_mem_type_out(ctrl_mem_type_out), .ctrl_wdata_out(ctrl_wdata_out),
    .ctrl_flash_data_in(ctrl_flash_data_in), .ctrl_flash_valid_in(ctrl_flash_valid_in),
    .ctrl_psram_data_in(ctrl_psram_data_in), .ctrl_psram_valid_in(ctrl_psram_valid_in),
    .ctrl_busy_in(ctrl_busy_in)
  );

  function automatic logic [15:0] flash_word(input logic [15:0] a);
    case (a)
      16'h0004: return 16'hA55A;
      16'h0006: return 16'h1234;
      default:  return ~a;
    endcase
  endfunction

  // Controller model: busy for 3 cycles after each address pulse, data valid as busy falls
  always @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ctrl_busy_in        <= 1'b0;
      ctrl_flash_valid_in <= 1'b0;
      ctrl_psram_valid_in <= 1'b0;
      ctrl_flash_data_in  <= 16'h0000;
      ctrl_psram_data_in  <= 8'h00;
      mdl_active          <= 1'b0;
      mdl_cnt             <= 0;
      mdl_type            <= TYPE_IMEM_READ;
      mdl_addr            <= 16'h0000;
      mdl_wdata           <= 8'h00;
      for (int i = 0; i < 256; i++) psram[i] <= 8'h00;
    end else begin
      ctrl_flash_valid_in <= 1'b0;
      ctrl_psram_valid_in <= 1'b0;
      if (ctrl_addr_valid_out) begin
        pulse_cnt  <= pulse_cnt + 1;
        mdl_active <= 1'b1;
        mdl_cnt    <= 0;
        mdl_type   <= ctrl_mem_type_out;
        mdl_addr   <= ctrl_addr_out;
        mdl_wdata  <= ctrl_wdata_out;
      end else if (mdl_active) begin
        if (mdl_cnt == 3) begin
          ctrl_busy_in <= 1'b0;
          mdl_active   <= 1'b0;
          case (mdl_type)
            TYPE_IMEM_READ: begin
              ctrl_flash_data_in  <= flash_word(mdl_addr);
              ctrl_flash_valid_in <= 1'b1;
            end
            TYPE_DMEM_READ: begin
              ctrl_psram_data_in  <= psram[mdl_addr[7:0]];
              ctrl_psram_valid_in <= 1'b1;
            end
            default: psram[mdl_addr[7:0]] <= mdl_wdata;
          endcase
        end else begin
          ctrl_busy_in <= 1'b1;
          mdl_cnt      <= mdl_cnt + 1;
        end
      end
    end
  end

  task automatic do_reset();
    imem_req_in   = 1'b0;
    dmem_req_in   = 1'b0;
    imem_addr_in  = '0;
    dmem_addr_in  = '0;
    dmem_we_in    = 1'b0;
    dmem_wdata_in = 8'h00;
    reset_in      = 1'b0;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
  endtask

  // which: 0 = imem ack, 1 = dmem ack, -1 = no ack within budget
  task automatic wait_any_ack(output int which, output int cyc);
    which = -1;
    cyc   = 0;
    while (which < 0 && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
      if (imem_ack_out) which = 0;
      else if (dmem_ack_out) which = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_ack_out !== 1'b0 || dmem_ack_out !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b expected 00", imem_ack_out, dmem_ack_out); end
    checks++; if (imem_data_out !== 16'h0000) begin errors++; $display("FAIL reset_imem_data: got %h expected 0000", imem_data_out); end
    checks++; if (dmem_rdata_out !== 8'h00) begin errors++; $display("FAIL reset_dmem_rdata: got %h expected 00", dmem_rdata_out); end
    checks++; if (ctrl_addr_out !== 16'h0000 || ctrl_addr_valid_out !== 1'b0) begin errors++; $display("FAIL reset_ctrl_addr: got %h/%b expected 0000/0", ctrl_addr_out, ctrl_addr_valid_out); end
    checks++; if (ctrl_mem_type_out !== TYPE_IMEM_READ || ctrl_wdata_out !== 8'h00) begin errors++; $display("FAIL reset_ctrl_type_wdata: got %0d/%h expected 0/00", ctrl_mem_type_out, ctrl_wdata_out); end
  endtask

  task automatic test_imem_fetch();
    int which, cyc, p0;
    p0 = pulse_cnt;
    imem_addr_in = 16'h0004;
    imem_req_in  = 1'b1;
    @(negedge clk_in);
    checks++; if (ctrl_addr_valid_out !== 1'b1 || ctrl_addr_out !== 16'h0004 || ctrl_mem_type_out !== TYPE_IMEM_READ) begin
      errors++; $display("FAIL fetch_issue: got valid=%b addr=%h type=%0d expected 1/0004/0", ctrl_addr_valid_out, ctrl_addr_out, ctrl_mem_type_out); end
    @(negedge clk_in);
    checks++; if (ctrl_addr_valid_out !== 1'b0) begin errors++; $display("FAIL fetch_valid_width: got %b expected 0", ctrl_addr_valid_out); end
    wait_any_ack(which, cyc);
    checks++; if (which !== 0 || cyc + 2 !== 7) begin errors++; $display("FAIL fetch_ack_latency: got port=%0d cycles=%0d expected 0/7", which, cyc + 2); end
    checks++; if (imem_data_out !== 16'hA55A) begin errors++; $display("FAIL fetch_data: got %h expected a55a", imem_data_out); end
    imem_req_in = 1'b0;
    @(negedge clk_in);
    checks++; if (imem_ack_out !== 1'b0 || imem_data_out !== 16'hA55A) begin errors++; $display("FAIL fetch_ack_pulse: got ack=%b data=%h expected 0/a55a", imem_ack_out, imem_data_out); end
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL fetch_pulse_count: got %0d expected 1", pulse_cnt - p0); end
    @(negedge clk_in);
  endtask

  task automatic test_dmem_rw();
    int which, cyc;
    logic [7:0] prev;
    prev          = dmem_rdata_out;
    dmem_addr_in  = 16'h0004;
    dmem_we_in    = 1'b1;
    dmem_wdata_in = 8'h55;
    dmem_req_in   = 1'b1;
    wait_any_ack(which, cyc);
    checks++; if (which !== 1) begin errors++; $display("FAIL dmem_write_ack: got port=%0d expected 1", which); end
    checks++; if (dmem_rdata_out !== prev) begin errors++; $display("FAIL dmem_write_rdata: got %h expected %h", dmem_rdata_out, prev); end
    checks++; if (mdl_type !== TYPE_DMEM_WRITE || psram[4] !== 8'h55) begin errors++; $display("FAIL dmem_write_type: got type=%0d mem=%h expected 2/55", mdl_type, psram[4]); end
    dmem_req_in = 1'b0;
    repeat (2) @(negedge clk_in);
    dmem_we_in  = 1'b0;
    dmem_req_in = 1'b1;
    wait_any_ack(which, cyc);
    checks++; if (which !== 1 || dmem_rdata_out !== 8'h55) begin errors++; $display("FAIL dmem_read: got port=%0d rdata=%h expected 1/55", which, dmem_rdata_out); end
    checks++; if (mdl_type !== TYPE_DMEM_READ) begin errors++; $display("FAIL dmem_read_type: got %0d expected 1", mdl_type); end
    dmem_req_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_round_robin();
    int which, cyc;
    do_reset();
    imem_addr_in = 16'h0004;
    dmem_addr_in = 16'h0004;
    dmem_we_in   = 1'b0;
    imem_req_in  = 1'b1;
    dmem_req_in  = 1'b1;
    wait_any_ack(which, cyc);
    checks++; if (which !== 0) begin errors++; $display("FAIL tie_first: got port=%0d expected 0", which); end
    imem_req_in = 1'b0;
    wait_any_ack(which, cyc);
    checks++; if (which !== 1) begin errors++; $display("FAIL tie_second: got port=%0d expected 1", which); end
    dmem_req_in = 1'b0;
    repeat (2) @(negedge clk_in);
    imem_req_in = 1'b1;
    dmem_req_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(which, cyc);
      checks++; if (which !== k % 2) begin errors++; $display("FAIL alternate_%0d: got port=%0d expected %0d", k, which, k % 2); end
    end
    imem_req_in = 1'b0;
    dmem_req_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_hold_past_ack();
    int which, cyc, p0, extra;
    p0 = pulse_cnt;
    imem_addr_in = 16'h0004;
    imem_req_in  = 1'b1;
    wait_any_ack(which, cyc);
    checks++; if (which !== 0) begin errors++; $display("FAIL hold_ack: got port=%0d expected 0", which); end
    @(negedge clk_in);
    imem_req_in = 1'b0;
    extra = 0;
    repeat (15) begin
      @(negedge clk_in);
      if (imem_ack_out) extra++;
    end
    checks++; if (pulse_cnt - p0 !== 1 || extra !== 0) begin errors++; $display("FAIL hold_no_regrant: got pulses=%0d acks=%0d expected 1/0", pulse_cnt - p0, extra); end
  endtask

  task automatic test_reset_mid();
    int which, cyc, n;
    imem_addr_in = 16'h0004;
    imem_req_in  = 1'b1;
    n = 0;
    while (ctrl_busy_in !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    checks++; if (ctrl_busy_in !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b expected 1", ctrl_busy_in); end
    @(negedge clk_in);
    reset_in = 1'b0;
    #1;
    checks++; if (imem_data_out !== 16'h0000 || imem_ack_out !== 1'b0 || ctrl_addr_out !== 16'h0000) begin
      errors++; $display("FAIL midreset_outputs: got data=%h ack=%b addr=%h expected 0000/0/0000", imem_data_out, imem_ack_out, ctrl_addr_out); end
    imem_req_in = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (imem_ack_out || dmem_ack_out) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL midreset_no_ack: got %0d acks expected 0", n); end
    reset_in = 1'b1;
    @(negedge clk_in);
    imem_req_in = 1'b1;
    wait_any_ack(which, cyc);
    checks++; if (which !== 0 || imem_data_out !== 16'hA55A) begin errors++; $display("FAIL midreset_refetch: got port=%0d data=%h expected 0/a55a", which, imem_data_out); end
    imem_req_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_fetch_buffer();
    int which, cyc, p0;
    imem_addr_in = 16'h0004;
    imem_req_in  = 1'b1;
    wait_any_ack(which, cyc);
    imem_req_in = 1'b0;
    repeat (2) @(negedge clk_in);
    p0 = pulse_cnt;
    imem_req_in = 1'b1;
    wait_any_ack(which, cyc);
    imem_req_in = 1'b0;
`ifdef SPI_ARB_FETCH_BUF_EN
    checks++; if (which !== 0 || cyc !== 1 || pulse_cnt - p0 !== 0) begin
      errors++; $display("FAIL buf_hit: got port=%0d cycles=%0d pulses=%0d expected 0/1/0", which, cyc, pulse_cnt - p0); end
`else
    checks++; if (which !== 0 || cyc !== 7 || pulse_cnt - p0 !== 1) begin
      errors++; $display("FAIL refetch_nobuf: got port=%0d cycles=%0d pulses=%0d expected 0/7/1", which, cyc, pulse_cnt - p0); end
`endif
    checks++; if (imem_data_out !== 16'hA55A) begin errors++; $display("FAIL refetch_data: got %h expected a55a", imem_data_out); end
    repeat (2) @(negedge clk_in);
    p0 = pulse_cnt;
    imem_addr_in = 16'h0006;
    imem_req_in  = 1'b1;
    wait_any_ack(which, cyc);
    imem_req_in = 1'b0;
    checks++; if (which !== 0 || pulse_cnt - p0 !== 1 || imem_data_out !== 16'h1234) begin
      errors++; $display("FAIL fetch_other: got port=%0d pulses=%0d data=%h expected 0/1/1234", which, pulse_cnt - p0, imem_data_out); end
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_imem_fetch();
    test_dmem_rw();
    test_round_robin();
    test_hold_past_ack();
    test_reset_mid();
    test_fetch_buffer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Two-port request arbiter directly upstream of `spi_flash_controller`. It accepts instruction fetches (16-bit, from SPI flash) and data reads/writes (8-bit, to SPI PSRAM) from the CPU core. It serialises them onto the controller's single `addr_valid_in` / `busy_out` interface and returns each result on the issuing port with a one-cycle acknowledge. An optional one-entry fetch buffer answers repeated fetches of the same address without any SPI traffic.

## Interface
Parameters:
- `ADDR_W`, 16, address width on both ports and toward the controller.

Ports:
- `clk_in`  in  1  system clock; all state changes on its rising edge.
- `reset_in`  in  1  reset, asynchronous, active-low.
- `imem_req_in`  in  1  fetch request; level, held until `imem_ack_out`.
- `imem_addr_in`  in  ADDR_W  fetch address; stable while `imem_req_in` is high.
- `imem_data_out`  out  16  fetched instruction word; valid while `imem_ack_out` is high.
- `imem_ack_out`  out  1  one-cycle fetch-done pulse.
- `dmem_req_in`  in  1  data request; level, held until `dmem_ack_out`.
- `dmem_we_in`  in  1  1 = write, 0 = read.
- `dmem_addr_in`  in  ADDR_W  data address.
- `dmem_wdata_in`  in  8  write data.
- `dmem_rdata_out`  out  8  read data; valid while `dmem_ack_out` is high (read only).
- `dmem_ack_out`  out  1  one-cycle data-done pulse.
- `ctrl_addr_out`  out  ADDR_W  to controller `addr_in`.
- `ctrl_addr_valid_out`  out  1  to controller `addr_valid_in`; one-cycle pulse.
- `ctrl_mem_type_out`  out  mem_type_t  to controller `mem_type_in`.
- `ctrl_wdata_out`  out  8  to controller `psram_data_in`.
- `ctrl_flash_data_in`  in  16  from controller `flash_data_out`.
- `ctrl_flash_valid_in`  in  1  from controller `flash_data_valid_out`.
- `ctrl_psram_data_in`  in  8  from controller `psram_data_out`.
- `ctrl_psram_valid_in`  in  1  from controller `psram_data_valid_out`.
- `ctrl_busy_in`  in  1  from controller `busy_out`.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: grant the pending request, if any.
  - If only one port requests, grant it.
  - If both request, grant the port not granted last (round-robin). The `last_grant` register resets to DMEM, so IMEM wins the first tie.
  - On grant, latch address, type and wdata into the `ctrl_*` output registers, then go to ISSUE.
  - Type mapping: IMEM → `TYPE_IMEM_READ`; DMEM with `we=0` → `TYPE_DMEM_READ`; DMEM with `we=1` → `TYPE_DMEM_WRITE`.
- ISSUE: `ctrl_addr_valid_out=1` for exactly this cycle, then WAIT_BUSY.
- WAIT_BUSY: wait for `ctrl_busy_in=1`, then WAIT_DONE.
- WAIT_DONE: wait for `ctrl_busy_in=0`, then RESP.
- Data capture:
  - A `ctrl_flash_valid_in` pulse in any WAIT state loads the 16-bit result register.
  - A `ctrl_psram_valid_in` pulse loads its low byte.
  - Valid pulses outside WAIT states are ignored.
- RESP: raise the granted port's ack for one cycle, then return to IDLE unconditionally. Requests are never sampled in RESP, so a requester dropping its req on the edge after ack is never re-granted.
- `imem_data_out` and `dmem_rdata_out` hold their last captured value until the next capture.
- Requests arriving while busy stay pending; nothing is queued beyond the two req levels.
- Reset (async, any state): FSM → IDLE, all outputs and registers → 0, `last_grant` → DMEM, fetch buffer invalid.

## Timing
- Reset values: every output 0, including `ctrl_mem_type_out = TYPE_IMEM_READ` (encoding 0).
- Req seen high at edge E0 in IDLE:
  - ISSUE during E0→E1.
  - `ctrl_addr_valid_out` high in that cycle only.
- Ack is asserted for the one cycle after the edge on which `busy_in` is sampled low in WAIT_DONE.
- Minimum SPI turnaround: 4 cycles plus the controller busy time.
- Back-to-back: the earliest next grant is 2 edges after the ack edge.
- Ack and data come from registers; no combinational path from `ctrl_*` inputs to any port output.

## Configuration
- `SPI_ARB_FETCH_BUF_EN` defined:
  - Add a tag register (ADDR_W) plus valid bit.
  - Every completed flash fetch loads the tag and the data, and sets valid.
  - An IMEM grant whose address equals the valid tag goes IDLE→RESP directly: ack one cycle after the request edge, no controller activity.
  - Flash is read-only, so only reset clears valid.
- Not defined: every fetch goes through the controller; no tag logic is present.

## Structure
- Shared package (already holding `mem_type_t` and its `TYPE_IMEM_READ` / `TYPE_DMEM_READ` / `TYPE_DMEM_WRITE` values): add `arb_state_t` and the `grant_t` (IMEM/DMEM) enum.
- The design is a single module; no sub-module is needed. The fetch buffer is small enough to live inline under the macro.

## Test plan
- Bench setup: arbiter + controller + flash/PSRAM models; flash word at 0x0004 = 0xA55A, PSRAM 0x0004 = 0x00.
- IMEM fetch 0x0004 → exactly one `ctrl_addr_valid_out` pulse with type `TYPE_IMEM_READ`; `imem_ack_out` one cycle with `imem_data_out=0xA55A`.
- DMEM write 0x0004 = 0x55, then DMEM read 0x0004 → write ack with no rdata change; read ack with `dmem_rdata_out=0x55`.
- Both req raised on the same edge after reset → IMEM served first, DMEM second. Repeat both held → grants alternate I, D, I, D.
- Req held one cycle past ack → no second `ctrl_addr_valid_out` pulse.
- `reset_in` low during WAIT_DONE → all outputs 0 immediately with no ack. After release, a fresh fetch of 0x0004 completes with 0xA55A.
- With `SPI_ARB_FETCH_BUF_EN`, fetch 0x0004 twice → second ack arrives one cycle after req with `0xA55A` and no `ctrl_addr_valid_out` pulse. Fetch 0x0006 → SPI access occurs.
